demux_1x2: RTL



---
 rtl/demux_pkg.sv | 7 +
 rtl/out_slot.sv | 32 +++
 rtl/demux_1x2.sv | 74 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared destination codes and default word width for the operand demux/mux
package demux_pkg;
  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;
  // Default word width, shared with the 2:1 operand mux
  localparam int DEMUX_DATA_WIDTH = 8;
endpackage

// File: rtl/out_slot.sv
// rtl/out_slot.sv - one-entry output holding register with independent backpressure
module out_slot
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEMUX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  output logic                  canAccept
);

  assign canAccept = ~outValid | outReady;

  // A load wins over a drain so drain-and-refill keeps the slot full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData  <= '0;
      outValid <= 1'b0;
    end else if (load) begin
      outData  <= loadData;
      outValid <= 1'b1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x2.sv
// rtl/demux_1x2.sv - registered 1-to-2 stream demux; DEMUX_ROUND_ROBIN_EN replaces sel with an A/B toggle
module demux_1x2
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEMUX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inValid,
  input  logic                  sel,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] outData_A,
  output logic                  outValid_A,
  input  logic                  outReady_A,
  output logic [DATA_WIDTH-1:0] outData_B,
  output logic                  outValid_B,
  input  logic                  outReady_B
);

  logic dest;
  logic can_a;
  logic can_b;
  logic in_hs;
  logic load_a;
  logic load_b;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic toggle;
  logic unused_sel;

  assign unused_sel = sel;
  assign dest       = toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= DEST_A;
    end else if (in_hs) begin
      toggle <= ~toggle;
    end
  end
`else
  assign dest = sel;
`endif

  // Only the selected destination's slot gates the input
  assign inReady = (dest == DEST_B) ? can_b : can_a;
  assign in_hs   = inValid & inReady;
  assign load_a  = in_hs & (dest == DEST_A);
  assign load_b  = in_hs & (dest == DEST_B);

  out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .loadData  (inData),
    .outReady  (outReady_A),
    .outData   (outData_A),
    .outValid  (outValid_A),
    .canAccept (can_a)
  );

  out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .loadData  (inData),
    .outReady  (outReady_B),
    .outData   (outData_B),
    .outValid  (outValid_B),
    .canAccept (can_b)
  );

endmodule
